// File: rtl/ddr_test_sequencer_if.sv
// Command channel between the DDR test sequencer and the AXI4 burst engine.
// The sequencer is the master and the engine is the slave.
interface ddr_test_sequencer_if #(
   parameter int ADDR_W = 34
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_dir;
   logic              cmd_done;

   modport master (
      output cmd_valid, cmd_addr, cmd_dir,
      input  cmd_ready, cmd_done
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_dir,
      output cmd_ready, cmd_done
   );
endinterface

// File: rtl/ddr_test_sequencer.sv
// Issues one full-region DDR test pass as fixed-size bursts with a bounded
// number of commands in flight, and reports elapsed cycles and status.
module ddr_test_sequencer #(
   parameter int                ADDR_W          = 34,
   parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
   parameter int                BURST_BYTES     = 4096,
   parameter int                REGION_BYTES    = 1 << 30,
   parameter int                MAX_OUTSTANDING = 4
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start_write,
   input  logic                        start_read,
   ddr_test_sequencer_if.master        cmd,
   output logic                        busy,
   output logic                        done,
   output logic [31:0]                 elapsed,
   output logic                        start_ignored,
   output logic                        proto_err
);
   localparam int NUM_BURSTS = REGION_BYTES / BURST_BYTES;
   localparam int CNT_W      = $clog2(NUM_BURSTS + 1);

   localparam logic [CNT_W-1:0]  NUM_C  = CNT_W'(NUM_BURSTS);
   localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(NUM_BURSTS - 1);
   localparam logic [3:0]        MAX_C  = 4'(MAX_OUTSTANDING);
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(BURST_BYTES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] issued;
   logic [CNT_W-1:0] completed;
   logic [3:0]       outstanding;
   logic             accept;
   logic             retire;
   logic             start;

   assign cmd.cmd_valid = (state == S_ISSUE) &&
                          (issued < NUM_C) &&
                          (outstanding < MAX_C);

   assign accept = cmd.cmd_valid & cmd.cmd_ready;
   assign retire = cmd.cmd_done & (outstanding != 4'd0);
   assign start  = start_write | start_read;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= S_IDLE;
         issued        <= '0;
         completed     <= '0;
         outstanding   <= '0;
         cmd.cmd_addr  <= BASE_ADDR;
         cmd.cmd_dir   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         elapsed       <= '0;
         start_ignored <= 1'b0;
         proto_err     <= 1'b0;
      end else begin
         done <= 1'b0;

         if (accept) begin
            issued       <= issued + 1'b1;
            cmd.cmd_addr <= cmd.cmd_addr + STEP;
         end

         if (retire)
            completed <= completed + 1'b1;

         if (accept && !retire)
            outstanding <= outstanding + 4'd1;
         else if (!accept && retire)
            outstanding <= outstanding - 4'd1;

         if (busy && (elapsed != '1))
            elapsed <= elapsed + 32'd1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state         <= S_ISSUE;
                  busy          <= 1'b1;
                  cmd.cmd_dir   <= ~start_write;
                  cmd.cmd_addr  <= BASE_ADDR;
                  issued        <= '0;
                  completed     <= '0;
                  outstanding   <= '0;
                  elapsed       <= '0;
                  start_ignored <= 1'b0;
                  proto_err     <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (accept && (issued == LAST_C))
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (retire && (completed == LAST_C)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Error flags set after the start clear so a same-cycle event sticks.
         if (start && busy)
            start_ignored <= 1'b1;
         if (cmd.cmd_done && (outstanding == 4'd0))
            proto_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ddr_test_sequencer.sv
// Self-checking bench: vector table, directed corner sequences and
// randomized passes checked against a cycle-level behavioural model.
module tb_ddr_test_sequencer;
   localparam int          NB   = 4;
   localparam int          MAXO = 2;
   localparam logic [33:0] BASE = 34'h1000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start_write;
   logic        start_read;
   logic        busy;
   logic        done;
   logic [31:0] elapsed;
   logic        start_ignored;
   logic        proto_err;

   ddr_test_sequencer_if #(.ADDR_W(34)) cmd_if();

   ddr_test_sequencer #(
      .ADDR_W          (34),
      .BASE_ADDR       (BASE),
      .BURST_BYTES     (4096),
      .REGION_BYTES    (16384),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .start_write   (start_write),
      .start_read    (start_read),
      .cmd           (cmd_if),
      .busy          (busy),
      .done          (done),
      .elapsed       (elapsed),
      .start_ignored (start_ignored),
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Behavioural model: counts of issued/completed bursts, no state machine.
   logic        m_busy, m_dir, m_done, m_sig, m_perr;
   int          m_iss, m_comp, m_out;
   logic [33:0] m_addr;
   logic [31:0] m_el;

   function automatic logic m_valid();
      return m_busy && (m_iss < NB) && (m_out < MAXO);
   endfunction

   task automatic model_edge(input logic sw, sr, rdy, dn, rn);
      logic acc, ret, was_busy, perr_set;
      if (!rn) begin
         m_busy = 0; m_dir = 0; m_done = 0; m_sig = 0; m_perr = 0;
         m_iss = 0; m_comp = 0; m_out = 0; m_addr = BASE; m_el = 0;
         return;
      end
      acc      = m_valid() && rdy;
      ret      = dn && (m_out > 0);
      perr_set = dn && (m_out == 0);
      was_busy = m_busy;
      m_done   = 0;
      if (was_busy && m_el != 32'hFFFF_FFFF) m_el = m_el + 1;
      if (acc) begin
         m_iss  = m_iss + 1;
         m_addr = m_addr + 34'h1000;
      end
      if (ret) m_comp = m_comp + 1;
      m_out = m_out + int'(acc) - int'(ret);
      if (was_busy) begin
         if (sw || sr) m_sig = 1;
         if (m_comp == NB) begin
            m_busy = 0;
            m_done = 1;
         end
      end else if (sw || sr) begin
         m_busy = 1; m_dir = !sw; m_iss = 0; m_comp = 0; m_out = 0;
         m_el = 0; m_addr = BASE; m_sig = 0; m_perr = 0;
      end
      if (perr_set) m_perr = 1;
   endtask

   task automatic step(input logic sw, sr, rdy, dn, rn);
      start_write      = sw;
      start_read       = sr;
      cmd_if.cmd_ready = rdy;
      cmd_if.cmd_done  = dn;
      resetn           = rn;
      @(posedge clk);
      model_edge(sw, sr, rdy, dn, rn);
      #1;
      chk("m_valid", 64'(cmd_if.cmd_valid), 64'(m_valid()));
      chk("m_addr", 64'(cmd_if.cmd_addr), 64'(m_addr));
      chk("m_dir", 64'(cmd_if.cmd_dir), 64'(m_dir));
      chk("m_busy", 64'(busy), 64'(m_busy));
      chk("m_done", 64'(done), 64'(m_done));
      chk("m_elapsed", 64'(elapsed), 64'(m_el));
      chk("m_start_ignored", 64'(start_ignored), 64'(m_sig));
      chk("m_proto_err", 64'(proto_err), 64'(m_perr));
   endtask

   // Engine: random ready, in-order cmd_done at least dly cycles after accept.
   task automatic run_pass(input logic sw, sr, edir, input int rdy_pct,
                           input int dly, inj, pre_busy);
      int acc, ncomp, dcnt, bcyc, cyc, last_dn, done_at, last_due;
      int due[$];
      logic rdy, dn;
      logic [33:0] ea;
      acc = 0; ncomp = 0; dcnt = 0; bcyc = pre_busy; cyc = 0;
      last_dn = -1; done_at = -1; last_due = 0;
      if (sw || sr) begin
         step(sw, sr, 1'b0, 1'b0, 1'b1);
         if (busy) bcyc++;
      end
      while (cyc < 300 && (done_at < 0 || cyc < done_at + 2)) begin
         cyc++;
         rdy = ($urandom_range(0, 99) < rdy_pct);
         dn  = 1'b0;
         if (due.size() != 0 && due[0] <= cyc) begin
            dn = 1'b1;
            void'(due.pop_front());
         end
         if (cmd_if.cmd_valid && rdy) begin
            ea = BASE + 34'(acc * 4096);
            chk("addr_order", 64'(cmd_if.cmd_addr), 64'(ea));
            chk("pass_dir", 64'(cmd_if.cmd_dir), 64'(edir));
            acc++;
            last_due = (cyc + dly > last_due + 1) ? cyc + dly : last_due + 1;
            due.push_back(last_due);
         end
         step(1'b0, logic'(cyc == inj), rdy, dn, 1'b1);
         if (dn) begin
            ncomp++;
            if (ncomp == NB) last_dn = cyc;
         end
         chk("outstanding_le_max", 64'(acc - ncomp <= MAXO), 64'd1);
         if (busy) bcyc++;
         if (done) begin
            dcnt++;
            done_at = cyc;
         end
      end
      chk("accepted", 64'(acc), 64'(NB));
      chk("done_pulses", 64'(dcnt), 64'd1);
      chk("done_latency", 64'(done_at), 64'(last_dn));
      chk("elapsed_busy", 64'(elapsed), 64'(bcyc));
   endtask

   typedef struct {
      logic        sw, sr, rdy, dn, rn;
      logic        valid, busy, done, dir, perr;
      logic [33:0] addr;
      logic [31:0] el;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic sw, sr;
      // sw sr rdy dn rn | valid busy done dir perr | addr | elapsed
      tbl[0]  = '{1,0,0,0,1, 1,1,0,0,0, 34'h1000, 0};
      tbl[1]  = '{0,0,1,0,1, 1,1,0,0,0, 34'h2000, 1};
      tbl[2]  = '{0,0,1,1,1, 1,1,0,0,0, 34'h3000, 2};
      tbl[3]  = '{0,0,1,1,1, 1,1,0,0,0, 34'h4000, 3};
      tbl[4]  = '{0,0,1,1,1, 0,1,0,0,0, 34'h5000, 4};
      tbl[5]  = '{0,0,0,1,1, 0,0,1,0,0, 34'h5000, 5};
      tbl[6]  = '{0,0,0,0,1, 0,0,0,0,0, 34'h5000, 5};
      tbl[7]  = '{0,0,0,1,1, 0,0,0,0,1, 34'h5000, 5};
      tbl[8]  = '{0,1,0,0,1, 1,1,0,1,0, 34'h1000, 0};
      tbl[9]  = '{0,0,1,0,1, 1,1,0,1,0, 34'h2000, 1};
      tbl[10] = '{0,0,1,0,1, 0,1,0,1,0, 34'h3000, 2};
      tbl[11] = '{0,0,0,1,1, 1,1,0,1,0, 34'h3000, 3};
      tbl[12] = '{0,0,0,0,0, 0,0,0,0,0, 34'h1000, 0};
      tbl[13] = '{0,0,0,1,1, 0,0,0,0,1, 34'h1000, 0};

      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("reset_valid", 64'(cmd_if.cmd_valid), 64'd0);
      chk("reset_addr", 64'(cmd_if.cmd_addr), 64'(BASE));
      chk("reset_elapsed", 64'(elapsed), 64'd0);

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].sw, tbl[i].sr, tbl[i].rdy, tbl[i].dn, tbl[i].rn);
         chk($sformatf("tbl%0d_valid", i), 64'(cmd_if.cmd_valid),
             64'(tbl[i].valid));
         chk($sformatf("tbl%0d_addr", i), 64'(cmd_if.cmd_addr),
             64'(tbl[i].addr));
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
         chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].done));
         chk($sformatf("tbl%0d_dir", i), 64'(cmd_if.cmd_dir),
             64'(tbl[i].dir));
         chk($sformatf("tbl%0d_perr", i), 64'(proto_err), 64'(tbl[i].perr));
         chk($sformatf("tbl%0d_elapsed", i), 64'(elapsed), 64'(tbl[i].el));
      end

      // Basic write pass, done 3 cycles after each acceptance
      run_pass(1, 0, 0, 100, 3, 0, 0);

      // Backpressure on the first read command
      step(0, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 1);
         chk("stall_valid", 64'(cmd_if.cmd_valid), 64'd1);
         chk("stall_addr", 64'(cmd_if.cmd_addr), 64'(BASE));
         chk("stall_dir", 64'(cmd_if.cmd_dir), 64'd1);
      end
      run_pass(0, 0, 1, 100, 2, 0, 6);

      // Both starts together: write wins
      run_pass(1, 1, 0, 100, 1, 0, 0);

      // Start while busy is dropped and flagged
      run_pass(1, 0, 0, 100, 2, 3, 0);
      chk("start_ignored_set", 64'(start_ignored), 64'd1);
      run_pass(0, 1, 1, 70, 2, 0, 0);
      chk("start_ignored_clr", 64'(start_ignored), 64'd0);

      // Reset after the 2nd acceptance, stale completion, fresh pass
      step(1, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("rst_mid_valid", 64'(cmd_if.cmd_valid), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_elapsed", 64'(elapsed), 64'd0);
      step(0, 0, 0, 1, 1);
      chk("stale_done_perr", 64'(proto_err), 64'd1);
      run_pass(1, 0, 0, 100, 2, 0, 0);

      // Elapsed with one-cycle completion latency
      run_pass(1, 0, 0, 100, 1, 0, 0);

      for (int k = 0; k < 12; k++) begin
         sw = 1'($urandom_range(0, 1));
         sr = sw ? 1'($urandom_range(0, 1)) : 1'b1;
         run_pass(sw, sr, !sw, $urandom_range(25, 100),
                  $urandom_range(1, 6), $urandom_range(0, 4), 0);
         if ($urandom_range(0, 2) == 0) step(0, 0, 0, 1, 1);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++)
            step(0, 0, 0, 0, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
